// File: rtl/lsu_mem_master.sv
// Load/store initiator between the core datapath and a big-endian, byte-addressed
// 64-bit data memory. Sub-dword stores are carried out as read-modify-write;
// every access finishes with a one-cycle done pulse.
module lsu_mem_master #(
  parameter int DW = 64,
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t        state;
  logic          we_q;
  logic          sext_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rbuf;
  logic [DW-1:0] mem_wdata_q;

  // Merge right-aligned store data into the top bytes of the old memory word.
  function automatic logic [DW-1:0] merge_store(input logic [1:0] sz,
                                                input logic [DW-1:0] wd,
                                                input logic [DW-1:0] old);
    logic [DW-1:0] res;
    case (sz)
      2'd0:    res = {wd[7:0],  old[55:0]};
      2'd1:    res = {wd[15:0], old[47:0]};
      2'd2:    res = {wd[31:0], old[31:0]};
      default: res = wd;
    endcase
    return res;
  endfunction

  // Pull the addressed bytes off the top of the read word and extend them.
  function automatic logic [DW-1:0] extract_load(input logic [1:0] sz,
                                                 input logic sx,
                                                 input logic [DW-1:0] word);
    logic signed [7:0]    b;
    logic signed [15:0]   h;
    logic signed [31:0]   w;
    logic signed [DW-1:0] res;
    b = word[63:56];
    h = word[63:48];
    w = word[63:32];
    case (sz)
      2'd0:    res = sx ? DW'(b) : {56'd0, word[63:56]};
      2'd1:    res = sx ? DW'(h) : {48'd0, word[63:48]};
      2'd2:    res = sx ? DW'(w) : {32'd0, word[63:32]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Access sequencer: latch request, read old word, write merged word, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      sext_q      <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf        <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            sext_q  <= sext;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (we && size == 2'd3) begin
              mem_wdata_q <= wdata;
              state       <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          rbuf <= mem_rdata;
          if (we_q) begin
            mem_wdata_q <= merge_store(size_q, wdata_q, mem_rdata);
            state       <= WR;
          end else begin
            state <= RESP;
          end
        end
        WR:      state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign ready     = (state == IDLE);
  assign done      = (state == RESP);
  assign mem_rd    = (state == RD);
  assign mem_wr    = (state == WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = (done && !we_q) ? extract_load(size_q, sext_q, rbuf) : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed scenarios plus randomized
// accesses against a byte-level reference memory model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        sext = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        ready;
  logic        done;
  logic [63:0] rdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_rdata;

  logic [63:0] mem [0:31];
  logic [63:0] ref_mem [0:31];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = '0;
  logic [63:0] pl_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_master #(.DW(64), .AW(64)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: combinational read, posedge write, plus a preload port for the bench.
  assign mem_rdata = mem[mem_addr[4:0]];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[4:0]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  function automatic logic [63:0] nmask(input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    return (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
  endfunction

  // Expected load: the first n bytes of the word, most significant first.
  function automatic logic [63:0] ref_load(input logic [63:0] word, input logic [1:0] sz,
                                           input logic sx);
    int nb;
    logic [63:0] m, v;
    nb = 1 << sz;
    m  = nmask(sz);
    v  = (word >> (64 - 8 * nb)) & m;
    if (sx && nb < 8 && v[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  // Expected memory word after storing n bytes at the start of the word.
  function automatic logic [63:0] ref_store(input logic [63:0] old, input logic [63:0] wd,
                                            input logic [1:0] sz);
    int nb;
    logic [63:0] m;
    nb = 1 << sz;
    m  = nmask(sz);
    return (old & ~(m << (64 - 8 * nb))) | ((wd & m) << (64 - 8 * nb));
  endfunction

  task automatic preload(input logic [4:0] idx, input logic [63:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = data;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (ready !== 1'b1) begin
      $display("FAIL ready_wait: ready=%b, required 1", ready);
      n_fail++;
    end
  endtask

  // One complete access, checked cycle by cycle against the reference model.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [63:0] a, input logic [63:0] wd,
                           output logic [63:0] got_rdata, output logic [63:0] got_wdata);
    logic [4:0]  idx;
    logic [63:0] exp_rdata, exp_word;
    int lat, exp_rd, done_cyc, rd_cyc, wr_cyc, rd_cnt, wr_cnt;
    logic both, bad_addr;
    idx       = a[4:0];
    exp_rdata = w ? 64'd0 : ref_load(ref_mem[idx], sz, sx);
    exp_word  = w ? ref_store(ref_mem[idx], wd, sz) : ref_mem[idx];
    lat       = (w && sz != 2'd3) ? 3 : 2;
    exp_rd    = (w && sz == 2'd3) ? 0 : 1;
    wait_ready();
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    done_cyc = -1; rd_cyc = -1; wr_cyc = -1; rd_cnt = 0; wr_cnt = 0;
    both = 1'b0; bad_addr = 1'b0; got_rdata = '0; got_wdata = '0;
    for (int c = 1; c <= 6 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req = 1'b0; we = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      end
      if (mem_rd && mem_wr) both = 1'b1;
      if (mem_rd) begin rd_cnt++; rd_cyc = c; if (mem_addr !== a) bad_addr = 1'b1; end
      if (mem_wr) begin
        wr_cnt++; wr_cyc = c; got_wdata = mem_wdata;
        if (mem_addr !== a) bad_addr = 1'b1;
      end
      if (done === 1'b1) begin done_cyc = c; got_rdata = rdata; end
    end
    n_tests++;
    if (done_cyc != lat) begin
      $display("FAIL latency: done in cycle %0d, required %0d (we=%b size=%0d)", done_cyc, lat, w, sz);
      n_fail++;
    end
    n_tests++;
    if (rd_cnt != exp_rd || (exp_rd == 1 && rd_cyc != 1)) begin
      $display("FAIL mem_rd: %0d cycles (last %0d), required %0d in cycle 1", rd_cnt, rd_cyc, exp_rd);
      n_fail++;
    end
    n_tests++;
    if (wr_cnt != int'(w) || (w && wr_cyc != lat - 1)) begin
      $display("FAIL mem_wr: %0d cycles (last %0d), required %0d in cycle %0d", wr_cnt, wr_cyc, w, lat - 1);
      n_fail++;
    end
    n_tests++;
    if (both !== 1'b0 || bad_addr !== 1'b0) begin
      $display("FAIL strobe_addr: both=%b bad_addr=%b, required 0/0", both, bad_addr);
      n_fail++;
    end
    n_tests++;
    if (got_rdata !== exp_rdata) begin
      $display("FAIL rdata: got %h, required %h (we=%b size=%0d sext=%b)", got_rdata, exp_rdata, w, sz, sx);
      n_fail++;
    end
    if (w) begin
      n_tests++;
      if (got_wdata !== exp_word) begin
        $display("FAIL mem_wdata: got %h, required %h (size=%0d)", got_wdata, exp_word, sz);
        n_fail++;
      end
    end
    n_tests++;
    if (mem[idx] !== exp_word) begin
      $display("FAIL mem_word: got %h, required %h", mem[idx], exp_word);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      $display("FAIL done_pulse: done=%b ready=%b after response, required 0/1", done, ready);
      n_fail++;
    end
    ref_mem[idx] = exp_word;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({ready, done, mem_rd, mem_wr} !== 4'b1000) begin
      $display("FAIL reset_ctrl: ready/done/rd/wr=%b, required 1000", {ready, done, mem_rd, mem_wr});
      n_fail++;
    end
    n_tests++;
    if (rdata !== 64'd0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
      $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h, required 0", rdata, mem_addr, mem_wdata);
      n_fail++;
    end
    for (int i = 0; i < 32; i++) preload(5'(i), {$urandom, $urandom});
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid_rmw();
    logic wr_seen;
    preload(5'd8, 64'hCAFE_F00D_1234_5678);
    wait_ready();
    req = 1'b1; we = 1'b1; size = 2'd1; sext = 1'b0; addr = 64'h8; wdata = 64'h1234;
    @(negedge clk);
    req = 1'b0;
    n_tests++;
    if (mem_rd !== 1'b1) begin
      $display("FAIL rmw_rd: mem_rd=%b in cycle 1, required 1", mem_rd);
      n_fail++;
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || ready !== 1'b1 || mem_addr !== 64'd0) begin
      $display("FAIL rst_async: wr=%b rd=%b ready=%b mem_addr=%h, required 0/0/1/0", mem_wr, mem_rd, ready, mem_addr);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    wr_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_wr) wr_seen = 1'b1;
    end
    n_tests++;
    if (wr_seen !== 1'b0 || mem[8] !== ref_mem[8]) begin
      $display("FAIL rst_no_write: wr_seen=%b word=%h, required 0 and %h", wr_seen, mem[8], ref_mem[8]);
      n_fail++;
    end
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0 || rdata !== 64'd0) begin
      $display("FAIL rst_idle: ready=%b done=%b rdata=%h, required 1/0/0", ready, done, rdata);
      n_fail++;
    end
  endtask

  task automatic test_directed();
    logic [63:0] r, wv;
    preload(5'd16, 64'h80AB_CDEF_0123_4567);
    do_access(1'b0, 2'd0, 1'b1, 64'h10, 64'd0, r, wv);
    n_tests++;
    if (r !== 64'hFFFF_FFFF_FFFF_FF80) begin
      $display("FAIL load_byte_sext: got %h, required ffffffffffffff80", r);
      n_fail++;
    end
    preload(5'd0, 64'h1122_3344_5566_7788);
    do_access(1'b1, 2'd1, 1'b0, 64'h20, 64'hBEEF, r, wv);
    n_tests++;
    if (wv !== 64'hBEEF_3344_5566_7788) begin
      $display("FAIL store_half: got %h, required beef334455667788", wv);
      n_fail++;
    end
    do_access(1'b1, 2'd3, 1'b0, 64'h18, 64'h0123_4567_89AB_CDEF, r, wv);
    n_tests++;
    if (wv !== 64'h0123_4567_89AB_CDEF || r !== 64'd0) begin
      $display("FAIL store_dword: wdata=%h rdata=%h, required 0123456789abcdef/0", wv, r);
      n_fail++;
    end
    preload(5'd8, 64'h89AB_CDEF_0000_0000);
    do_access(1'b0, 2'd2, 1'b0, 64'h28, 64'd0, r, wv);
    n_tests++;
    if (r !== 64'h0000_0000_89AB_CDEF) begin
      $display("FAIL load_word_zext: got %h, required 0000000089abcdef", r);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int dn;
    int dc [2];
    logic [63:0] dv [2];
    logic [63:0] e1, e2;
    preload(5'd3, 64'hF00D_1111_2222_3333);
    preload(5'd5, 64'h9C00_0000_0000_0000);
    e1 = ref_load(ref_mem[3], 2'd1, 1'b1);
    e2 = ref_load(ref_mem[5], 2'd0, 1'b0);
    dn = 0; dc[0] = -1; dc[1] = -1; dv[0] = '0; dv[1] = '0;
    wait_ready();
    req = 1'b1; we = 1'b0; size = 2'd1; sext = 1'b1; addr = 64'h103;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin size = 2'd0; sext = 1'b0; addr = 64'h45; end
      if (c == 4) req = 1'b0;
      if (c == 3) begin
        n_tests++;
        if (ready !== 1'b1) begin
          $display("FAIL b2b_ready: ready=%b in cycle 3, required 1", ready);
          n_fail++;
        end
      end
      if (done === 1'b1) begin
        if (dn < 2) begin dc[dn] = c; dv[dn] = rdata; end
        dn++;
      end
    end
    n_tests++;
    if (dn != 2 || dc[0] != 2 || dc[1] != 5) begin
      $display("FAIL b2b_timing: %0d dones at %0d,%0d, required 2 at 2,5", dn, dc[0], dc[1]);
      n_fail++;
    end
    n_tests++;
    if (dv[0] !== e1 || dv[1] !== e2) begin
      $display("FAIL b2b_data: got %h,%h, required %h,%h", dv[0], dv[1], e1, e2);
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic [63:0] r, wv;
    for (int i = 0; i < 60; i++) begin
      do_access(1'($urandom), 2'($urandom), 1'($urandom), {$urandom, $urandom},
                {$urandom, $urandom}, r, wv);
    end
  endtask

  initial begin
    test_reset();
    test_rst_mid_rmw();
    test_directed();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
